// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing controller.
// Moore FSM plus ALU and immediate-type decode for a shared-datapath core.
module multicycle_controller #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       RegWrite,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_e     state_q;
    state_e     state_d;
    state_e     cur;
    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;

    // State register; reset aborts any instruction back to FETCH.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECR,
            S_EXECI,
            S_JAL:      state_d = S_ALUWB;
            S_MEMWB,
            S_MEMWRITE,
            S_ALUWB,
            S_BEQ:      state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore outputs; during reset the FETCH decode is shown with enables off.
    always_comb begin
        cur       = Reset ? S_FETCH : state_q;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = 2'b00;
        pc_update = 1'b0;
        branch    = 1'b0;
        case (cur)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_update = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: begin
            end
        endcase
        if (Reset) begin
            IRWrite   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            pc_update = 1'b0;
            branch    = 1'b0;
        end
        PCWrite = pc_update | (branch & Zero);
    end

    // ALU operation decode from ALUOp and the instruction fields.
    always_comb begin
        ALUControl = 4'b0000;
        case (alu_op)
            2'b00: ALUControl = 4'b0000;
            2'b01: ALUControl = 4'b0001;
            default: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 4'b0001 : 4'b0000;
                    3'b001:  ALUControl = 4'b0110;
                    3'b010:  ALUControl = 4'b0101;
                    3'b011:  ALUControl = 4'b1001;
                    3'b100:  ALUControl = 4'b0100;
                    3'b101:  ALUControl = funct7b5 ? 4'b1000 : 4'b0111;
                    3'b110:  ALUControl = 4'b0011;
                    default: ALUControl = 4'b0010;
                endcase
            end
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign state   = state_q;
    assign illegal = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller.
// Second instance covers the ILLEGAL_HALT = 0 build.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       Reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [3:0] ALUControl, state;

    logic       PCWrite2, AdrSrc2, MemWrite2, IRWrite2, RegWrite2, illegal2;
    logic [1:0] ResultSrc2, ALUSrcA2, ALUSrcB2, ImmSrc2;
    logic [3:0] ALUControl2, state2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut (
        .clk(clk), .Reset(Reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .RegWrite(RegWrite), .state(state), .illegal(illegal)
    );

    multicycle_controller #(.ILLEGAL_HALT(1'b0)) dut_nop (
        .clk(clk), .Reset(Reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .Zero(Zero),
        .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .MemWrite(MemWrite2),
        .IRWrite(IRWrite2), .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2),
        .ALUSrcB(ALUSrcB2), .ImmSrc(ImmSrc2), .ALUControl(ALUControl2),
        .RegWrite(RegWrite2), .state(state2), .illegal(illegal2)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enables_off(input string tag);
        chk({tag, ".PCWrite"}, {7'd0, PCWrite}, 8'd0);
        chk({tag, ".IRWrite"}, {7'd0, IRWrite}, 8'd0);
        chk({tag, ".MemWrite"}, {7'd0, MemWrite}, 8'd0);
        chk({tag, ".RegWrite"}, {7'd0, RegWrite}, 8'd0);
    endtask

    initial begin
        Reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;

        // reset held two cycles
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst.state", {4'd0, state}, 8'd0);
            chk("rst.PCWrite", {7'd0, PCWrite}, 8'd0);
            chk("rst.IRWrite", {7'd0, IRWrite}, 8'd0);
        end
        Reset = 1'b0;
        #1;
        chk("fetch.IRWrite", {7'd0, IRWrite}, 8'd1);
        chk("fetch.PCWrite", {7'd0, PCWrite}, 8'd1);
        chk("fetch.ALUSrcB", {6'd0, ALUSrcB}, 8'd2);
        chk("fetch.ResultSrc", {6'd0, ResultSrc}, 8'd2);

        // lw
        op = 7'b0000011;
        tick(); chk("lw.s1", {4'd0, state}, 8'd1);
        chk("lw.dec.ALUSrcA", {6'd0, ALUSrcA}, 8'd1);
        tick(); chk("lw.s2", {4'd0, state}, 8'd2);
        chk("lw.adr.ALUSrcA", {6'd0, ALUSrcA}, 8'd2);
        tick(); chk("lw.s3", {4'd0, state}, 8'd3);
        chk("lw.AdrSrc", {7'd0, AdrSrc}, 8'd1);
        chk("lw.s3.RegWrite", {7'd0, RegWrite}, 8'd0);
        tick(); chk("lw.s4", {4'd0, state}, 8'd4);
        chk("lw.RegWrite", {7'd0, RegWrite}, 8'd1);
        chk("lw.ResultSrc", {6'd0, ResultSrc}, 8'd1);
        tick(); chk("lw.s0", {4'd0, state}, 8'd0);

        // sw
        op = 7'b0100011;
        #1;
        chk("sw.ImmSrc0", {6'd0, ImmSrc}, 8'd1);
        chk("sw.s0.MemWrite", {7'd0, MemWrite}, 8'd0);
        tick(); chk("sw.s1", {4'd0, state}, 8'd1);
        tick(); chk("sw.s2", {4'd0, state}, 8'd2);
        chk("sw.s2.MemWrite", {7'd0, MemWrite}, 8'd0);
        tick(); chk("sw.s5", {4'd0, state}, 8'd5);
        chk("sw.MemWrite", {7'd0, MemWrite}, 8'd1);
        chk("sw.ImmSrc5", {6'd0, ImmSrc}, 8'd1);
        tick(); chk("sw.s0", {4'd0, state}, 8'd0);

        // R-type sub
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        tick(); chk("sub.s1", {4'd0, state}, 8'd1);
        tick(); chk("sub.s6", {4'd0, state}, 8'd6);
        chk("sub.ALUControl", {4'd0, ALUControl}, 8'h01);
        tick(); chk("sub.s8", {4'd0, state}, 8'd8);
        chk("sub.RegWrite", {7'd0, RegWrite}, 8'd1);
        tick(); chk("sub.s0", {4'd0, state}, 8'd0);

        // srai
        op = 7'b0010011; funct3 = 3'b101; funct7b5 = 1'b1;
        tick(); tick(); chk("srai.s7", {4'd0, state}, 8'd7);
        chk("srai.ALUControl", {4'd0, ALUControl}, 8'h08);
        tick(); tick(); chk("srai.s0", {4'd0, state}, 8'd0);

        // addi with funct7b5 set must still add
        funct3 = 3'b000; funct7b5 = 1'b1;
        tick(); tick(); chk("addi.s7", {4'd0, state}, 8'd7);
        chk("addi.ALUControl", {4'd0, ALUControl}, 8'h00);
        tick(); tick(); chk("addi.s0", {4'd0, state}, 8'd0);
        funct7b5 = 1'b0;

        // beq taken
        op = 7'b1100011; Zero = 1'b1;
        tick(); chk("beqt.s1", {4'd0, state}, 8'd1);
        chk("beqt.dec.PCWrite", {7'd0, PCWrite}, 8'd0);
        tick(); chk("beqt.s9", {4'd0, state}, 8'd9);
        chk("beqt.PCWrite", {7'd0, PCWrite}, 8'd1);
        chk("beqt.ALUControl", {4'd0, ALUControl}, 8'h01);
        tick(); chk("beqt.s0", {4'd0, state}, 8'd0);

        // beq not taken
        Zero = 1'b0;
        tick(); tick(); chk("beqn.s9", {4'd0, state}, 8'd9);
        chk("beqn.PCWrite", {7'd0, PCWrite}, 8'd0);
        tick(); chk("beqn.s0", {4'd0, state}, 8'd0);

        // jal
        op = 7'b1101111;
        #1;
        chk("jal.ImmSrc", {6'd0, ImmSrc}, 8'd3);
        tick(); chk("jal.s1", {4'd0, state}, 8'd1);
        tick(); chk("jal.s10", {4'd0, state}, 8'd10);
        chk("jal.PCWrite", {7'd0, PCWrite}, 8'd1);
        chk("jal.ALUSrcB", {6'd0, ALUSrcB}, 8'd2);
        tick(); chk("jal.s8", {4'd0, state}, 8'd8);
        tick(); chk("jal.s0", {4'd0, state}, 8'd0);

        // illegal opcode on both builds
        op = 7'b1111111;
        tick(); chk("ill.s1", {4'd0, state}, 8'd1);
        chk("nop.s1", {4'd0, state2}, 8'd1);
        tick(); chk("ill.s11", {4'd0, state}, 8'd11);
        chk("nop.s0", {4'd0, state2}, 8'd0);
        chk("nop.illegal", {7'd0, illegal2}, 8'd0);
        for (int i = 0; i < 5; i++) begin
            chk("ill.state", {4'd0, state}, 8'd11);
            chk("ill.flag", {7'd0, illegal}, 8'd1);
            enables_off("ill");
            tick();
        end
        Reset = 1'b1;
        #1;
        enables_off("ill.rst");
        tick(); chk("ill.rst.s0", {4'd0, state}, 8'd0);
        chk("ill.rst.flag", {7'd0, illegal}, 8'd0);
        chk("nop.rst.s0", {4'd0, state2}, 8'd0);
        Reset = 1'b0;

        // reset during MEMWRITE
        op = 7'b0100011;
        tick(); tick(); tick(); chk("swr.s5", {4'd0, state}, 8'd5);
        Reset = 1'b1;
        #1;
        chk("swr.MemWrite", {7'd0, MemWrite}, 8'd0);
        chk("swr.AdrSrc", {7'd0, AdrSrc}, 8'd0);
        tick(); chk("swr.s0", {4'd0, state}, 8'd0);
        Reset = 1'b0;
        #1;
        chk("swr.IRWrite", {7'd0, IRWrite}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
